dma_mem_responder: RTL and testbench

//  Memory-side responder for the DMA controller's single-port master bus (mem_addr/mem_r_en/
//  mem_w_en/mem_write -> mem_read). Word-organised synchronous RAM with byte addressing,

---
 rtl/dma_mem_responder.sv | 120 ++++++++++++
 tb/tb_dma_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// Word-organised scratch RAM answering the DMA master bus with a configurable read latency.
// It also checks address range and alignment, captures the first error, and counts accesses.
module dma_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_addr,
  input  logic                     mem_r_en,
  input  logic                     mem_w_en,
  input  logic [31:0]              mem_write,
  output logic [31:0]              mem_read,
  output logic                     rd_valid,
  output logic                     err,
  output logic [31:0]              err_addr,
  input  logic                     err_clr,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_idx,
  input  logic [31:0]              init_data
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [30:0] DEPTH_W   = 31'(DEPTH);

  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_pipe_data [READ_LAT];
  logic [READ_LAT-1:0] r_pipe_vld;
  logic                r_err;
  logic [31:0]         r_err_addr;
  logic [15:0]         r_rd_count;
  logic [15:0]         r_wr_count;

  logic [29:0]         w_word;
  logic [AW-1:0]       w_idx;
  logic                w_misaligned;
  logic                w_out_of_range;
  logic                w_bad;
  logic                w_any_bad;
  logic [31:0]         w_rd_data;

  // BASE_ADDR is word aligned, so the word offset is just the difference of the word fields.
  assign w_word         = mem_addr[31:2] - BASE_WORD;
  assign w_idx          = w_word[AW-1:0];
  assign w_misaligned   = (mem_addr[1:0] != 2'b00);
  assign w_out_of_range = (mem_addr < BASE_ADDR) || ({1'b0, w_word} >= DEPTH_W);
  assign w_bad          = w_misaligned | w_out_of_range;
  assign w_any_bad      = (mem_r_en | mem_w_en) & w_bad;
  assign w_rd_data      = w_bad ? ERR_DATA : r_mem[w_idx];

  // RAM array: bus writes win over the backdoor, and the RAM is never reset.
  always_ff @(posedge clk) begin
    if (mem_w_en && !w_bad) begin
      r_mem[w_idx] <= mem_write;
    end else if (init_we && !mem_w_en) begin
      r_mem[init_idx] <= init_data;
    end
  end

  // Read pipe: a stage loads data only behind a valid, so the last stage holds between returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        r_pipe_data[k] <= 32'h0000_0000;
      end
    end else begin
      r_pipe_vld[0] <= mem_r_en;
      if (mem_r_en) begin
        r_pipe_data[0] <= w_rd_data;
      end
      for (int k = 1; k < READ_LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_data[k] <= r_pipe_data[k-1];
        end
      end
    end
  end

  // Sticky error: only the first bad address is kept, and a same-edge clear lets a new one in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end else if (w_any_bad) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) begin
        r_err_addr <= mem_addr;
      end
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'h0000_0000;
    end
  end

  // Access counters count every accepted request, including bad ones, and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_count <= 16'h0000;
      r_wr_count <= 16'h0000;
    end else begin
      r_rd_count <= r_rd_count + {15'd0, mem_r_en};
      r_wr_count <= r_wr_count + {15'd0, mem_w_en};
    end
  end

  assign mem_read = r_pipe_data[READ_LAT-1];
  assign rd_valid = r_pipe_vld[READ_LAT-1];
  assign err      = r_err;
  assign err_addr = r_err_addr;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: a READ_LAT=1 instance and a READ_LAT=3 instance
// share one stimulus bus, and a bench-side loop acts as the DMA master.
module tb_dma_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_write;
  logic        err_clr;
  logic        init_we;
  logic [9:0]  init_idx;
  logic [31:0] init_data;

  logic [31:0] mem_read1, err_addr1, mem_read3, err_addr3;
  logic        rd_valid1, err1, rd_valid3, err3;
  logic [15:0] rd_count1, wr_count1, rd_count3, wr_count3;

  int checks;
  int errors;

  dma_mem_responder #(.READ_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_write(mem_write), .mem_read(mem_read1), .rd_valid(rd_valid1), .err(err1),
    .err_addr(err_addr1), .err_clr(err_clr), .rd_count(rd_count1), .wr_count(wr_count1),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data)
  );

  dma_mem_responder #(.READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_write(mem_write), .mem_read(mem_read3), .rd_valid(rd_valid3), .err(err3),
    .err_addr(err_addr3), .err_clr(err_clr), .rd_count(rd_count3), .wr_count(wr_count3),
    .init_we(init_we), .init_idx(init_idx), .init_data(init_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    err_clr  = 1'b0;
    init_we  = 1'b0;
  endtask

  task automatic init_word(input logic [9:0] idx, input logic [31:0] data);
    init_we = 1'b1; init_idx = idx; init_data = data;
    cyc();
    init_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_addr = 32'h0; mem_write = 32'h0; init_idx = 10'd0; init_data = 32'h0;
    repeat (3) cyc();
    checks++;
    if ({mem_read1, rd_valid1, err1, err_addr1, rd_count1, wr_count1} !== 98'h0) begin
      errors++;
      $display("FAIL reset_state got rd=%h v=%b e=%b ea=%h rc=%h wc=%h exp all 0",
               mem_read1, rd_valid1, err1, err_addr1, rd_count1, wr_count1);
    end
    rst = 1'b0;
    cyc();
    // one read in flight inside the 3-deep pipe when reset hits
    mem_addr = 32'h0; mem_r_en = 1'b1;
    cyc();
    mem_r_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_read1, rd_valid1, rd_count1, rd_count3} !== 65'h0) begin
      errors++;
      $display("FAIL reset_midstream got rd=%h v=%b rc=%h rc3=%h exp 0",
               mem_read1, rd_valid1, rd_count1, rd_count3);
    end
    #2;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      checks++;
      if (rd_valid3 !== 1'b0 || rd_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush cyc%0d got v1=%b v3=%b exp 0", j, rd_valid1, rd_valid3);
      end
    end
  endtask

  task automatic test_write_read();
    mem_addr = 32'h10; mem_write = 32'h1234_5678; mem_w_en = 1'b1;
    cyc();
    mem_w_en = 1'b0; mem_r_en = 1'b1;
    cyc();
    mem_r_en = 1'b0;
    checks++;
    if (rd_valid1 !== 1'b1 || mem_read1 !== 32'h1234_5678 || rd_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_lat1 got v=%b d=%h v3=%b exp 1 12345678 0", rd_valid1, mem_read1, rd_valid3);
    end
    cyc();
    checks++;
    if (rd_valid1 !== 1'b0 || mem_read1 !== 32'h1234_5678 || rd_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_hold got v=%b d=%h v3=%b exp 0 12345678 0", rd_valid1, mem_read1, rd_valid3);
    end
    cyc();
    checks++;
    if (rd_valid3 !== 1'b1 || mem_read3 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wr_rd_lat3 got v=%b d=%h exp 1 12345678", rd_valid3, mem_read3);
    end
    checks++;
    if (rd_count1 !== 16'd1 || wr_count1 !== 16'd1 || rd_count3 !== 16'd1) begin
      errors++;
      $display("FAIL wr_rd_counts got rc=%0d wc=%0d rc3=%0d exp 1 1 1", rd_count1, wr_count1, rd_count3);
    end
    cyc();
  endtask

  task automatic test_same_cycle();
    init_word(10'd8, 32'h5555_5555);
    init_word(10'd10, 32'h3333_3333);
    mem_addr = 32'h20; mem_write = 32'hAAAA_AAAA; mem_w_en = 1'b1; mem_r_en = 1'b1;
    cyc();
    checks++;
    if (rd_valid1 !== 1'b1 || mem_read1 !== 32'h5555_5555) begin
      errors++;
      $display("FAIL rw_same_old got v=%b d=%h exp 1 55555555", rd_valid1, mem_read1);
    end
    // bus write to idx 9 while the backdoor targets idx 10: backdoor must be ignored
    mem_r_en = 1'b0; mem_addr = 32'h24; mem_write = 32'h1111_1111;
    init_we = 1'b1; init_idx = 10'd10; init_data = 32'h2222_2222;
    cyc();
    idle();
    mem_addr = 32'h20; mem_r_en = 1'b1;
    cyc();
    mem_addr = 32'h28;
    checks++;
    if (mem_read1 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL rw_same_new got %h exp aaaaaaaa", mem_read1);
    end
    cyc();
    mem_r_en = 1'b0;
    checks++;
    if (mem_read1 !== 32'h3333_3333) begin
      errors++;
      $display("FAIL backdoor_blocked got %h exp 33333333", mem_read1);
    end
    cyc();
  endtask

  task automatic test_error();
    init_word(10'd0, 32'hCAFE_F00D);
    mem_addr = 32'h2; mem_r_en = 1'b1;
    cyc();
    mem_r_en = 1'b0;
    checks++;
    if (mem_read1 !== 32'hDEAD_BEEF || rd_valid1 !== 1'b1 || err1 !== 1'b1 || err_addr1 !== 32'h2) begin
      errors++;
      $display("FAIL err_misaligned got d=%h v=%b e=%b ea=%h exp deadbeef 1 1 2",
               mem_read1, rd_valid1, err1, err_addr1);
    end
    mem_addr = 32'h1000; mem_write = 32'h9999_9999; mem_w_en = 1'b1;
    cyc();
    mem_w_en = 1'b0;
    checks++;
    if (err1 !== 1'b1 || err_addr1 !== 32'h2) begin
      errors++;
      $display("FAIL err_first_kept got e=%b ea=%h exp 1 2", err1, err_addr1);
    end
    mem_r_en = 1'b1;
    cyc();
    mem_addr = 32'h0;
    checks++;
    if (mem_read1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL err_range_data got %h exp deadbeef", mem_read1);
    end
    cyc();
    mem_r_en = 1'b0;
    checks++;
    if (mem_read1 !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL err_ram_unchanged got %h exp cafef00d", mem_read1);
    end
    err_clr = 1'b1; mem_addr = 32'h5; mem_r_en = 1'b1;
    cyc();
    mem_r_en = 1'b0;
    checks++;
    if (err1 !== 1'b1 || err_addr1 !== 32'h5) begin
      errors++;
      $display("FAIL err_clr_newwins got e=%b ea=%h exp 1 5", err1, err_addr1);
    end
    cyc();
    err_clr = 1'b0;
    checks++;
    if (err1 !== 1'b0 || err_addr1 !== 32'h0) begin
      errors++;
      $display("FAIL err_clear got e=%b ea=%h exp 0 0", err1, err_addr1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp1;
    logic [31:0] exp3;
    init_word(10'd0, 32'd1);
    init_word(10'd1, 32'd2);
    init_word(10'd2, 32'd3);
    for (int j = 0; j < 5; j++) begin
      mem_r_en = (j < 3);
      mem_addr = 32'(4 * j);
      cyc();
      exp1 = 32'(j + 1);
      exp3 = 32'(j - 1);
      checks++;
      if (rd_valid1 !== (j < 3) || (j < 3 && mem_read1 !== exp1)) begin
        errors++;
        $display("FAIL b2b_lat1 cyc%0d got v=%b d=%h exp v=%b d=%h", j, rd_valid1, mem_read1, (j < 3), exp1);
      end
      checks++;
      if (rd_valid3 !== (j >= 2) || (j >= 2 && mem_read3 !== exp3)) begin
        errors++;
        $display("FAIL b2b_lat3 cyc%0d got v=%b d=%h exp v=%b d=%h", j, rd_valid3, mem_read3, (j >= 2), exp3);
      end
    end
    mem_r_en = 1'b0;
    cyc();
  endtask

  task automatic test_dma_copy();
    logic [31:0] word;
    rst = 1'b1; #2; rst = 1'b0;
    for (int i = 0; i < 4; i++) init_word(10'(64 + i), 32'hA5A5_0000 + 32'(i * 17));
    // DMA master: issue a read, take the word two edges later, write it out
    for (int i = 0; i < 4; i++) begin
      mem_addr = 32'h100 + 32'(4 * i); mem_r_en = 1'b1;
      cyc();
      mem_r_en = 1'b0;
      cyc();
      word = mem_read1;
      mem_addr = 32'h200 + 32'(4 * i); mem_write = word; mem_w_en = 1'b1;
      cyc();
      mem_w_en = 1'b0;
    end
    checks++;
    if (rd_count1 !== 16'd4 || wr_count1 !== 16'd4 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL dma_counts got rc=%0d wc=%0d e=%b exp 4 4 0", rd_count1, wr_count1, err1);
    end
    for (int i = 0; i < 4; i++) begin
      mem_addr = 32'h200 + 32'(4 * i); mem_r_en = 1'b1;
      cyc();
      checks++;
      if (mem_read1 !== 32'hA5A5_0000 + 32'(i * 17)) begin
        errors++;
        $display("FAIL dma_dest%0d got %h exp %h", i, mem_read1, 32'hA5A5_0000 + 32'(i * 17));
      end
    end
    mem_r_en = 1'b0;
    cyc();
  endtask

  task automatic test_wrap();
    rst = 1'b1; #2; rst = 1'b0;
    mem_addr = 32'h3F0; mem_write = 32'h0; mem_w_en = 1'b1;
    repeat (65535) cyc();
    checks++;
    if (wr_count1 !== 16'hFFFF || rd_count1 !== 16'h0) begin
      errors++;
      $display("FAIL wrap_max got wc=%h rc=%h exp ffff 0", wr_count1, rd_count1);
    end
    cyc();
    mem_w_en = 1'b0;
    checks++;
    if (wr_count1 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero got %h exp 0000", wr_count1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_error();
    test_back_to_back();
    test_dma_copy();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
